// File: rtl/rbot_pkg.sv
// Shared move encoding and sequencer state definitions
// for the cube-solving robot motor sequencer.
package rbot_pkg;

    localparam int FACE_W    = 3;
    localparam int TURN_W    = 2;
    localparam int MOVE_W    = FACE_W + TURN_W;
    localparam int NUM_FACES = 6;

    localparam logic [FACE_W-1:0] FACE_U = 3'd0;
    localparam logic [FACE_W-1:0] FACE_D = 3'd1;
    localparam logic [FACE_W-1:0] FACE_L = 3'd2;
    localparam logic [FACE_W-1:0] FACE_R = 3'd3;
    localparam logic [FACE_W-1:0] FACE_F = 3'd4;
    localparam logic [FACE_W-1:0] FACE_B = 3'd5;

    localparam logic [TURN_W-1:0] TURN_RSVD = 2'b00;
    localparam logic [TURN_W-1:0] TURN_CW   = 2'b01;
    localparam logic [TURN_W-1:0] TURN_HALF = 2'b10;
    localparam logic [TURN_W-1:0] TURN_CCW  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FIRE,
        S_ARM,
        S_WAIT,
        S_SETTLE,
        S_FAULT
    } state_e;

    function automatic logic move_legal(input logic [MOVE_W-1:0] m);
        return (m[MOVE_W-1:TURN_W] < FACE_W'(NUM_FACES))
            && (m[TURN_W-1:0] != TURN_RSVD);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Synchronous move queue with occupancy count and
// a synchronous flush that empties it in one cycle.
module move_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Pointers carry one extra wrap bit so full and empty differ.
    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/move_sequencer.sv
// Dequeues face-turn moves and drives one motor at a
// time with a start pulse, done wait, timeout and settle gap.
module move_sequencer #(
    parameter int STEPS_QUARTER  = 50,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 24'hFF_FFFF,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [4:0] move_in,
    input  logic       move_valid,
    output logic       move_ready,
    output logic [5:0] motor_start,
    output logic [5:0] motor_dir,
    output logic [7:0] motor_steps,
    input  logic [5:0] motor_done,
    output logic       busy,
    output logic       bad_move,
    output logic       fault
);

    import rbot_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int SW = $clog2(SETTLE_CYCLES + 2);

    state_e state;
    state_e state_nxt;

    logic [MOVE_W-1:0] head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic              push;
    logic              pop;
    logic              flush;
    logic              legal;
    logic [FACE_W-1:0] head_face;
    logic [TURN_W-1:0] head_turn;
    logic [FACE_W-1:0] face_q;
    logic [FACE_W-1:0] face_d;
    logic [TW-1:0]     wait_cnt;
    logic [SW-1:0]     settle_cnt;

    logic [5:0] start_d;
    logic [5:0] dir_d;
    logic [7:0] steps_d;
    logic       bad_d;
    logic       fault_d;
    logic       busy_d;
    logic       ready_d;

    assign push      = move_valid && move_ready && !full;
    assign pop       = (state == S_LOAD);
    assign flush     = (state == S_FAULT);
    assign head_face = head[MOVE_W-1:TURN_W];
    assign head_turn = head[TURN_W-1:0];
    assign legal     = move_legal(head);

    move_fifo #(
        .WIDTH (MOVE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (move_in),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (cnt)
    );

    // Occupancy after this edge, so ready and busy can be registered.
    always_comb begin
        cnt_nxt = cnt;
        if (flush) begin
            cnt_nxt = '0;
        end else begin
            if (push)
                cnt_nxt = cnt_nxt + CW'(1);
            if (pop)
                cnt_nxt = cnt_nxt - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:
                if (!empty)
                    state_nxt = S_LOAD;
            S_LOAD:
                state_nxt = legal ? S_FIRE : S_IDLE;
            S_FIRE:
                state_nxt = S_ARM;
            S_ARM:
                state_nxt = S_WAIT;
            S_WAIT:
                if (motor_done[face_q])
                    state_nxt = S_SETTLE;
                else if (wait_cnt == TW'(TIMEOUT_CYCLES - 1))
                    state_nxt = S_FAULT;
            S_SETTLE:
                if (settle_cnt >= SW'(SETTLE_CYCLES))
                    state_nxt = S_IDLE;
            S_FAULT:
                state_nxt = S_FAULT;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            wait_cnt   <= (state == S_WAIT)
                        ? wait_cnt + TW'(1) : '0;
            settle_cnt <= (state == S_SETTLE)
                        ? settle_cnt + SW'(1) : '0;
        end
    end

    // Start is launched from LOAD so it is visible during FIRE.
    always_comb begin
        start_d = '0;
        dir_d   = motor_dir;
        steps_d = motor_steps;
        face_d  = face_q;
        bad_d   = 1'b0;
        if (state == S_LOAD) begin
            if (legal) begin
                face_d           = head_face;
                start_d          = 6'b1 << head_face;
                steps_d          = (head_turn == TURN_HALF)
                                 ? 8'(2 * STEPS_QUARTER)
                                 : 8'(STEPS_QUARTER);
                dir_d[head_face] = (head_turn != TURN_CCW);
            end else begin
                bad_d = 1'b1;
            end
        end
        fault_d = fault || (state_nxt == S_FAULT);
        busy_d  = (cnt_nxt != '0) || (state_nxt != S_IDLE);
        ready_d = !fault_d && (cnt_nxt < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            motor_start <= '0;
            motor_dir   <= '0;
            motor_steps <= '0;
            face_q      <= '0;
            bad_move    <= 1'b0;
            fault       <= 1'b0;
            busy        <= 1'b0;
            move_ready  <= 1'b0;
        end else begin
            motor_start <= start_d;
            motor_dir   <= dir_d;
            motor_steps <= steps_d;
            face_q      <= face_d;
            bad_move    <= bad_d;
            fault       <= fault_d;
            busy        <= busy_d;
            move_ready  <= ready_d;
        end
    end

endmodule
